// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
//   Command / response handshake bundle between the PDU command path and
//   the run controller.
//   master : PDU side  - drives cmd_valid/cmd_op/cmd_idx/cmd_data, resp_ready
//   slave  : controller - drives cmd_ready, resp_valid/resp_status/resp_data
//   cmd_op   : 0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 SET_BP, 5 CLR_BP, 6 CHECK, 7 READ_CNT
//   resp_status : 0 OK, 1 BP_HIT, 2 ERROR, 3 LIMIT
interface cpu_run_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_idx;
    logic [31:0] cmd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_data, resp_ready,
        input  cmd_ready, resp_valid, resp_status, resp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_data, resp_ready,
        output cmd_ready, resp_valid, resp_status, resp_data
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/step/breakpoint sequencer between the PDU command path and a
//   single-cycle CPU. Gates the CPU with a registered clock enable, counts
//   retired instructions, stops on PC breakpoints, sequences debug reads and
//   returns exactly one response per accepted command.
//
//   Parameters : BP_NUM (1..4) breakpoint registers,
//                CHECK_WAIT (>=1) cycles from cpu_check_addr to sampling.
//   Option     : define RUN_LIMIT_EN to build the RUN instruction limit
//                (RUN cmd_data != 0 loads a down-counter, status LIMIT).
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     bus (slave)       command/response handshake
//     current_pc/next_pc CPU PC of executing / following instruction
//     cpu_en            CPU clock enable (1 exactly in RUN and STEP)
//     cpu_check_addr/data debug read bus
//     halted            1 in HALT state
//     instret           retired-instruction counter
module cpu_run_ctrl #(
    parameter int unsigned BP_NUM     = 4,
    parameter int unsigned CHECK_WAIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus,
    input  logic [31:0]   current_pc,
    input  logic [31:0]   next_pc,
    output logic          cpu_en,
    output logic [31:0]   cpu_check_addr,
    input  logic [31:0]   cpu_check_data,
    output logic          halted,
    output logic [31:0]   instret
);

    typedef enum logic [2:0] {
        S_HALT, S_RUN, S_STEP, S_CHECK, S_RESP
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP, OP_RUN, OP_STEP, OP_HALT, OP_SET_BP, OP_CLR_BP, OP_CHECK, OP_READ_CNT
    } op_e;

    typedef enum logic [1:0] {
        ST_OK, ST_BP_HIT, ST_ERROR, ST_LIMIT
    } status_e;

    state_e      state_q, state_d;
    logic        cpu_en_q, cpu_en_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        halted_q, halted_d;
    logic        resp_valid_q, resp_valid_d;
    logic [1:0]  resp_status_q, resp_status_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [31:0] chk_addr_q, chk_addr_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] wait_q, wait_d;
    logic        ret_run_q, ret_run_d;
    logic [31:0] bp_addr_q [4];
    logic [31:0] bp_addr_d [4];
    logic [3:0]  bp_vld_q, bp_vld_d;

    op_e         op;
    logic        cmd_fire;
    logic        resp_fire;
    logic        idx_ok;
    logic        wait_last;
    logic        bp_hit;
    logic [31:0] bp_hit_addr;
    logic        lim_hit;

    assign op        = op_e'(bus.cmd_op);
    assign cmd_fire  = bus.cmd_valid && cmd_ready_q;
    assign resp_fire = resp_valid_q && bus.resp_ready;
    assign idx_ok    = (32'(bus.cmd_idx) < BP_NUM);
    assign wait_last = (wait_q == CHECK_WAIT - 1);

`ifdef RUN_LIMIT_EN
    logic        lim_en_q, lim_en_d;
    logic [31:0] lim_q, lim_d;
    // Counter holds instructions still allowed; the cycle retiring the last
    // one is the one that leaves RUN.
    assign lim_hit = lim_en_q && (lim_q == 32'd1);
`else
    assign lim_hit = 1'b0;
`endif

    // Only next_pc is compared, so the instruction sitting on a breakpoint
    // when RUN starts still executes.
    always_comb begin
        bp_hit      = 1'b0;
        bp_hit_addr = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!bp_hit && (i < BP_NUM) && bp_vld_q[i[1:0]] &&
                (next_pc == bp_addr_q[i[1:0]])) begin
                bp_hit      = 1'b1;
                bp_hit_addr = bp_addr_q[i[1:0]];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_HALT;
            cpu_en_q      <= 1'b0;
            cmd_ready_q   <= 1'b1;
            halted_q      <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_status_q <= '0;
            resp_data_q   <= '0;
            chk_addr_q    <= '0;
            instret_q     <= '0;
            wait_q        <= '0;
            ret_run_q     <= 1'b0;
            bp_vld_q      <= '0;
            for (int unsigned i = 0; i < 4; i++) bp_addr_q[i] <= '0;
`ifdef RUN_LIMIT_EN
            lim_en_q      <= 1'b0;
            lim_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cpu_en_q      <= cpu_en_d;
            cmd_ready_q   <= cmd_ready_d;
            halted_q      <= halted_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_data_q   <= resp_data_d;
            chk_addr_q    <= chk_addr_d;
            instret_q     <= instret_d;
            wait_q        <= wait_d;
            ret_run_q     <= ret_run_d;
            bp_vld_q      <= bp_vld_d;
            for (int unsigned i = 0; i < 4; i++) bp_addr_q[i] <= bp_addr_d[i];
`ifdef RUN_LIMIT_EN
            lim_en_q      <= lim_en_d;
            lim_q         <= lim_d;
`endif
        end
    end

    // Next-state logic. Breakpoint, then limit, then command decides RUN exit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALT: begin
                if (cmd_fire) begin
                    case (op)
                        OP_RUN:   state_d = S_RUN;
                        OP_STEP:  state_d = S_STEP;
                        OP_CHECK: state_d = S_CHECK;
                        default:  state_d = S_RESP;
                    endcase
                end
            end
            S_RUN:   if (bp_hit || lim_hit || cmd_fire) state_d = S_RESP;
            S_STEP:  state_d = S_RESP;
            S_CHECK: if (wait_last) state_d = S_RESP;
            S_RESP:  if (resp_fire) state_d = ret_run_q ? S_RUN : S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Output / datapath next values; all outputs are registered from state_d.
    always_comb begin
        resp_status_d = resp_status_q;
        resp_data_d   = resp_data_q;
        chk_addr_d    = chk_addr_q;
        wait_d        = wait_q;
        ret_run_d     = ret_run_q;
        bp_vld_d      = bp_vld_q;
        for (int unsigned i = 0; i < 4; i++) bp_addr_d[i] = bp_addr_q[i];
        instret_d     = instret_q + {31'd0, cpu_en_q};
`ifdef RUN_LIMIT_EN
        lim_en_d      = lim_en_q;
        lim_d         = lim_q;
`endif

        unique case (state_q)
            S_HALT: begin
                if (cmd_fire) begin
                    ret_run_d     = 1'b0;
                    resp_status_d = ST_OK;
                    resp_data_d   = '0;
                    case (op)
                        OP_NOP, OP_HALT: resp_data_d = current_pc;
                        OP_READ_CNT:     resp_data_d = instret_q;
                        OP_SET_BP: begin
                            if (idx_ok) begin
                                bp_addr_d[bus.cmd_idx] = {bus.cmd_data[31:2], 2'b00};
                                bp_vld_d[bus.cmd_idx]  = 1'b1;
                            end else begin
                                resp_status_d = ST_ERROR;
                            end
                        end
                        OP_CLR_BP: begin
                            if (idx_ok) bp_vld_d[bus.cmd_idx] = 1'b0;
                            else        resp_status_d = ST_ERROR;
                        end
                        OP_CHECK: begin
                            chk_addr_d = bus.cmd_data;
                            wait_d     = '0;
                        end
                        OP_RUN: begin
`ifdef RUN_LIMIT_EN
                            lim_en_d = (bus.cmd_data != '0);
                            lim_d    = bus.cmd_data;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
`ifdef RUN_LIMIT_EN
                if (lim_en_q) lim_d = lim_q - 32'd1;
`endif
                if (bp_hit) begin
                    resp_status_d = ST_BP_HIT;
                    resp_data_d   = bp_hit_addr;
                    ret_run_d     = 1'b0;
`ifdef RUN_LIMIT_EN
                    lim_en_d      = 1'b0;
`endif
                end else if (lim_hit) begin
                    // next_pc becomes current_pc once the CPU has stopped.
                    resp_status_d = ST_LIMIT;
                    resp_data_d   = next_pc;
                    ret_run_d     = 1'b0;
`ifdef RUN_LIMIT_EN
                    lim_en_d      = 1'b0;
`endif
                end else if (cmd_fire) begin
                    if (op == OP_HALT) begin
                        resp_status_d = ST_OK;
                        resp_data_d   = next_pc;
                        ret_run_d     = 1'b0;
`ifdef RUN_LIMIT_EN
                        lim_en_d      = 1'b0;
`endif
                    end else begin
                        // Rejected command: answer, then resume RUN.
                        resp_status_d = ST_ERROR;
                        resp_data_d   = '0;
                        ret_run_d     = 1'b1;
                    end
                end
            end
            S_STEP: begin
                resp_status_d = ST_OK;
                resp_data_d   = next_pc;
                ret_run_d     = 1'b0;
            end
            S_CHECK: begin
                wait_d = wait_q + 32'd1;
                if (wait_last) begin
                    resp_status_d = ST_OK;
                    resp_data_d   = cpu_check_data;
                end
            end
            default: ;
        endcase

        cpu_en_d     = (state_d == S_RUN) || (state_d == S_STEP);
        cmd_ready_d  = (state_d == S_HALT) || (state_d == S_RUN);
        halted_d     = (state_d == S_HALT);
        resp_valid_d = (state_d == S_RESP);
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_status = resp_status_q;
    assign bus.resp_data   = resp_data_q;
    assign cpu_en          = cpu_en_q;
    assign cpu_check_addr  = chk_addr_q;
    assign halted          = halted_q;
    assign instret         = instret_q;

endmodule
